// File: rtl/tiny_pkg.sv
// Shared TINY RISC definitions: word/byte geometry, default memory depth and
// the loader state encoding.
package tiny_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int IMEM_DEPTH     = 256;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_RD    = 3'd3,
        S_CMP   = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_e;

    // A load is in flight from start acceptance until a final status is held.
    function automatic logic is_busy(input state_e s);
        return s inside {S_RECV, S_WRITE, S_RD, S_CMP};
    endfunction

    function automatic logic accepts_start(input state_e s);
        return s inside {S_IDLE, S_DONE, S_ERROR};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, memory-port and status bundle of the instruction-memory loader.
// The master side is the loader; the slave side is the host plus the memory.
interface imem_loader_if
    import tiny_pkg::*;
#(
    parameter int CNT_W = 9
);
    logic                start;
    logic [CNT_W-1:0]    word_count;
    logic [BYTE_W-1:0]   byte_in;
    logic                byte_valid;
    logic                byte_ready;
    logic [WORD_W-1:0]   writeAddr;
    logic [WORD_W-1:0]   writeData;
    logic                wr;
    logic [WORD_W-1:0]   readAddr;
    logic [WORD_W-1:0]   readData;
    logic                busy;
    logic                done;
    logic                error;
    logic [CNT_W-1:0]    word_ptr;

    modport master (
        input  start, word_count, byte_in, byte_valid, readData,
        output byte_ready, writeAddr, writeData, wr, readAddr,
               busy, done, error, word_ptr
    );

    modport slave (
        output start, word_count, byte_in, byte_valid, readData,
        input  byte_ready, writeAddr, writeData, wr, readAddr,
               busy, done, error, word_ptr
    );

endinterface

// File: rtl/byte_packer.sv
// Big-endian word assembler: shifts accepted bytes in from the bottom so the
// first byte of a word ends up in the most significant lane.
module byte_packer
    import tiny_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_ready
);

    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES_PER_WORD - 1);

    logic [WORD_W-1:0] r_word;
    logic [BIDX_W-1:0] r_idx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_accept) begin
            r_word <= {r_word[WORD_W-BYTE_W-1:0], i_byte};
            r_idx  <= r_idx + BIDX_W'(1);
        end
    end

    // The index wraps back to zero on the fourth byte, ready for the next word.
    assign o_word_ready = i_accept && (r_idx == LAST_IDX);
    assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// Run-time program loader: packs a byte stream into words, writes them to the
// instruction memory from address 0, then verifies them by XOR readback.
module imem_loader
    import tiny_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int CNT_W = 9
)(
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_e            r_state;
    logic [CNT_W-1:0]  r_word_count;
    logic [CNT_W-1:0]  r_word_ptr;
    logic [CNT_W-1:0]  r_rd_idx;
    logic [WORD_W-1:0] r_wr_sum;
    logic [WORD_W-1:0] r_rd_sum;
    logic              r_rd_pending;

    logic              w_start_ok;
    logic              w_load_go;
    logic              w_accept;
    logic              w_word_ready;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_rd_final;

    assign w_start_ok = bus.start && accepts_start(r_state);
    assign w_load_go  = w_start_ok && (bus.word_count != '0) &&
                        (bus.word_count <= DEPTH_C);
    assign w_accept   = (r_state == S_RECV) && bus.byte_valid;

    // The word read in the last RD cycle arrives during CMP, so the final
    // comparison folds it in combinationally.
    assign w_rd_final = r_rd_pending ? (r_rd_sum ^ bus.readData) : r_rd_sum;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (w_load_go),
        .i_accept     (w_accept),
        .i_byte       (bus.byte_in),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_word_count <= '0;
            r_word_ptr   <= '0;
            r_rd_idx     <= '0;
            r_wr_sum     <= '0;
            r_rd_sum     <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            r_rd_pending <= (r_state == S_RD);
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_start_ok) begin
                        if (bus.word_count == '0) begin
                            r_state <= S_DONE;
                        end else if (bus.word_count > DEPTH_C) begin
                            r_state <= S_ERROR;
                        end else begin
                            r_state      <= S_RECV;
                            r_word_count <= bus.word_count;
                            r_word_ptr   <= '0;
                            r_rd_idx     <= '0;
                            r_wr_sum     <= '0;
                            r_rd_sum     <= '0;
                        end
                    end
                end
                S_RECV: begin
                    if (w_word_ready) begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_wr_sum   <= r_wr_sum ^ w_word;
                    r_word_ptr <= r_word_ptr + CNT_W'(1);
                    if (r_word_ptr + CNT_W'(1) == r_word_count) begin
                        r_state  <= S_RD;
                        r_rd_idx <= '0;
                    end else begin
                        r_state <= S_RECV;
                    end
                end
                S_RD: begin
                    // Data for the previous RD address is on readData now.
                    if (r_rd_pending) begin
                        r_rd_sum <= r_rd_sum ^ bus.readData;
                    end
                    r_rd_idx <= r_rd_idx + CNT_W'(1);
                    if (r_rd_idx + CNT_W'(1) == r_word_count) begin
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_rd_sum <= w_rd_final;
                    r_state  <= (w_rd_final == r_wr_sum) ? S_DONE : S_ERROR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset drops them without waiting for a clock edge.
    assign bus.byte_ready = (r_state == S_RECV);
    assign bus.wr         = (r_state == S_WRITE);
    assign bus.writeAddr  = WORD_W'(r_word_ptr);
    assign bus.writeData  = w_word;
    assign bus.readAddr   = WORD_W'(r_rd_idx);
    assign bus.busy       = is_busy(r_state);
    assign bus.done       = (r_state == S_DONE);
    assign bus.error      = (r_state == S_ERROR);
    assign bus.word_ptr   = r_word_ptr;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream feeder, instruction-memory
// model with optional readback corruption, and a write/readback monitor.
module tb_imem_loader;
    import tiny_pkg::*;

    logic clk;
    logic reset;

    imem_loader_if #(.CNT_W(9)) bus ();

    imem_loader #(.DEPTH(256), .CNT_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Byte stream: appended by the main flow, consumed on each handshake.
    logic [7:0]  stream [$];
    int          rd_ptr = 0;
    logic        feed_en = 1'b0;
    logic        toggle_mode = 1'b0;
    logic        phase = 1'b0;
    logic        corrupt = 1'b0;

    always @(negedge clk) begin
        phase          = ~phase;
        bus.byte_valid = feed_en && (rd_ptr < stream.size()) && (!toggle_mode || phase);
        bus.byte_in    = (rd_ptr < stream.size()) ? stream[rd_ptr] : 8'h00;
    end

    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.wr) mem[bus.writeAddr[7:0]] <= bus.writeData;
        bus.readData <= mem[bus.readAddr[7:0]] ^
                        {31'd0, (corrupt && bus.readAddr == 32'd3)};
    end

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] rd_addr_q [$];
    int          b2b_wr = 0;
    int          rdy_in_wr = 0;
    logic        prev_wr = 1'b0;

    always @(posedge clk) begin
        if (bus.byte_valid && bus.byte_ready && rd_ptr < stream.size()) rd_ptr++;
        if (bus.wr) begin
            wr_addr_q.push_back(bus.writeAddr);
            wr_data_q.push_back(bus.writeData);
            if (prev_wr) b2b_wr++;
            if (bus.byte_ready) rdy_in_wr++;
        end
        prev_wr = bus.wr;
        if (bus.busy && !bus.wr && !bus.byte_ready) rd_addr_q.push_back(bus.readAddr);
    end

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    // Returns at the falling edge after the edge that samples start.
    task automatic pulse_start(input logic [8:0] n);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.word_count = n;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    // Counts clock edges since (and including) the start-sampling edge.
    task automatic wait_status(input int first, input int limit, output int cycles);
        cycles = first;
        while (!(bus.done || bus.error) && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_writes(input string tag, input int base, input logic [31:0] exp_data [$]);
        check({tag, "_wr_count"}, 32'(wr_data_q.size() - base), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++) begin
            if (base + i < wr_data_q.size()) begin
                check($sformatf("%s_wr_addr[%0d]", tag, i), wr_addr_q[base + i], 32'(i));
                check($sformatf("%s_wr_data[%0d]", tag, i), wr_data_q[base + i], exp_data[i]);
            end
        end
    endtask

    initial begin
        int          cyc;
        int          wbase;
        int          rbase;
        logic [31:0] exp_q [$];

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.word_count = '0;
        #12;
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_wr",         32'(bus.wr),         32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        check("rst_error",      32'(bus.error),      32'd0);
        check("rst_writeAddr",  bus.writeAddr,       32'd0);
        check("rst_writeData",  bus.writeData,       32'd0);
        check("rst_readAddr",   bus.readAddr,        32'd0);
        check("rst_word_ptr",   32'(bus.word_ptr),   32'd0);
        @(negedge clk);
        reset   = 1'b0;
        feed_en = 1'b1;

        // 17 words, stream never stalls: done after 5*17+17+2 edges.
        exp_q.delete();
        for (int i = 0; i <= 16; i++) begin
            push_word(32'(i));
            exp_q.push_back(32'(i));
        end
        wbase = wr_data_q.size();
        rbase = rd_addr_q.size();
        pulse_start(9'd17);
        wait_status(1, 400, cyc);
        check("t1_cycles", 32'(cyc), 32'd104);
        check("t1_done",   32'(bus.done),  32'd1);
        check("t1_error",  32'(bus.error), 32'd0);
        check("t1_busy",   32'(bus.busy),  32'd0);
        check("t1_word_ptr", 32'(bus.word_ptr), 32'd17);
        check_writes("t1", wbase, exp_q);
        check("t1_rd_cycles", 32'(rd_addr_q.size() - rbase), 32'd18);
        for (int i = 0; i <= 16; i++) begin
            if (rbase + i < rd_addr_q.size())
                check($sformatf("t1_rd_addr[%0d]", i), rd_addr_q[rbase + i], 32'(i));
        end
        repeat (3) @(negedge clk);
        check("t1_done_held", 32'(bus.done), 32'd1);

        // One word with byte_valid toggling every other cycle.
        toggle_mode = 1'b1;
        push_word(32'hDEADBEEF);
        exp_q.delete();
        exp_q.push_back(32'hDEADBEEF);
        wbase = wr_data_q.size();
        pulse_start(9'd1);
        wait_status(1, 100, cyc);
        toggle_mode = 1'b0;
        check_writes("t2", wbase, exp_q);
        check("t2_done", 32'(bus.done), 32'd1);

        // Readback of address 3 corrupted: checksum mismatch.
        corrupt = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            push_word(32'h1000_0000 | 32'(i));
            exp_q.push_back(32'h1000_0000 | 32'(i));
        end
        wbase = wr_data_q.size();
        pulse_start(9'd8);
        wait_status(1, 200, cyc);
        corrupt = 1'b0;
        check("t3_cycles", 32'(cyc), 32'd50);
        check("t3_error", 32'(bus.error), 32'd1);
        check("t3_done",  32'(bus.done),  32'd0);
        check_writes("t3", wbase, exp_q);

        // Zero-length and oversized loads resolve on the next edge.
        wbase = wr_data_q.size();
        pulse_start(9'd0);
        wait_status(1, 20, cyc);
        check("t4_zero_cycles", 32'(cyc), 32'd1);
        check("t4_zero_done",   32'(bus.done),  32'd1);
        check("t4_zero_error",  32'(bus.error), 32'd0);
        pulse_start(9'd257);
        wait_status(1, 20, cyc);
        check("t4_big_cycles", 32'(cyc), 32'd1);
        check("t4_big_error",  32'(bus.error), 32'd1);
        check("t4_big_done",   32'(bus.done),  32'd0);
        check("t4_no_writes",  32'(wr_data_q.size() - wbase), 32'd0);

        // word_count = DEPTH is legal; reset lands after two bytes of word 0.
        stream.push_back(8'hAA);
        stream.push_back(8'hBB);
        pulse_start(9'd256);
        check("t5_busy_depth", 32'(bus.busy), 32'd1);
        repeat (2) @(negedge clk);
        check("t5_bytes_taken", 32'(stream.size() - rd_ptr), 32'd0);
        check("t5_ready_before", 32'(bus.byte_ready), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_ready", 32'(bus.byte_ready), 32'd0);
        check("t5_rst_wr",    32'(bus.wr),         32'd0);
        check("t5_rst_busy",  32'(bus.busy),       32'd0);
        @(negedge clk);
        reset = 1'b0;
        push_word(32'h01020304);
        exp_q.delete();
        exp_q.push_back(32'h01020304);
        wbase = wr_data_q.size();
        pulse_start(9'd1);
        wait_status(1, 50, cyc);
        check("t5_cycles", 32'(cyc), 32'd8);
        check("t5_done",   32'(bus.done), 32'd1);
        check_writes("t5", wbase, exp_q);

        // A start while busy (asking for an empty load) is ignored.
        push_word(32'hCAFEF00D);
        push_word(32'h12345678);
        exp_q.delete();
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'h12345678);
        wbase = wr_data_q.size();
        pulse_start(9'd2);
        repeat (3) @(negedge clk);
        bus.start      = 1'b1;
        bus.word_count = 9'd0;
        @(negedge clk);
        bus.start      = 1'b0;
        wait_status(5, 100, cyc);
        check("t6_cycles", 32'(cyc), 32'd14);
        check("t6_done",   32'(bus.done), 32'd1);
        check_writes("t6", wbase, exp_q);

        // A fresh start after done clears done and reloads.
        push_word(32'h0BADC0DE);
        exp_q.delete();
        exp_q.push_back(32'h0BADC0DE);
        wbase = wr_data_q.size();
        pulse_start(9'd1);
        check("t7_done_cleared", 32'(bus.done), 32'd0);
        check("t7_busy",         32'(bus.busy), 32'd1);
        wait_status(1, 50, cyc);
        check("t7_cycles", 32'(cyc), 32'd8);
        check("t7_done",   32'(bus.done), 32'd1);
        check_writes("t7", wbase, exp_q);

        check("wr_back_to_back", 32'(b2b_wr), 32'd0);
        check("ready_during_wr", 32'(rdy_in_wr), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
